// File: rtl/harris_pkg.sv
// Shared types, defaults and helpers for the Harris corner NMS stream.
package harris_pkg;

   // Default width of the signed Harris response.
   localparam int DEF_SCORE_W = 32;

   // Signed Harris score at the default width.
   typedef logic signed [DEF_SCORE_W-1:0] score_t;

   // Width of a coordinate counter that spans 0..n-1 (at least one bit).
   function automatic int coord_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/harris_line_buffer.sv
// One line of delay. The cell at the current column address is read
// (the sample from the previous line) and overwritten with the new sample
// on the same accepted cycle. The line therefore shifts by one column per
// write enable.
module harris_line_buffer #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 32,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Store the incoming sample at its column; contents are never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= din;
      end
   end

   assign dout = mem_q[addr];

endmodule

// File: rtl/harris_nms_stream.sv
// Streaming non-maximum suppression of Harris scores over a WIN x WIN window.
// Each accepted sample at (x,y) produces a decision for the center
// (x-R, y-R) one cycle later. Frame statistics are reported at the last pixel.
//
// Handshake: score_valid qualifies score/sof/threshold for one cycle. Every
// such cycle is accepted. There is no backpressure. corner_valid is a
// one-cycle qualifier for corner/cx/cy. No downstream ready exists.
module harris_nms_stream
   import harris_pkg::*;
#(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int SCORE_W = DEF_SCORE_W,
   parameter int WIN     = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [SCORE_W-1:0] score,
   input  logic                      score_valid,
   input  logic                      sof,
   input  logic signed [SCORE_W-1:0] threshold,
   output logic                      corner_valid,
   output logic                      corner,
   output logic [coord_w(IMG_W)-1:0] cx,
   output logic [coord_w(IMG_H)-1:0] cy,
   output logic                      frame_done,
   output logic [31:0]               corner_count
);

   localparam int R    = (WIN - 1) / 2;
   localparam int CX_W = coord_w(IMG_W);
   localparam int CY_W = coord_w(IMG_H);
   localparam int CIDX = R * WIN + R;   // raster index of the center inside the window

   localparam logic [CX_W-1:0] X_LAST = CX_W'(IMG_W - 1);
   localparam logic [CY_W-1:0] Y_LAST = CY_W'(IMG_H - 1);
   localparam logic [CX_W-1:0] X_MIN  = CX_W'(2 * R);
   localparam logic [CY_W-1:0] Y_MIN  = CY_W'(2 * R);
   localparam logic [CX_W-1:0] CX_OFF = CX_W'(R);
   localparam logic [CY_W-1:0] CY_OFF = CY_W'(R);

   // A sample is taken only when valid and not under reset.
   logic adv;
   assign adv = score_valid & ~reset;

   // Position counters: *_q is the position the next sample will take.
   logic [CX_W-1:0] col_q, col_d, cur_x;
   logic [CY_W-1:0] row_q, row_d, cur_y;

   // Column entering the window: index 0 is the oldest row, WIN-1 is the current row.
   logic signed [SCORE_W-1:0] col_new [WIN];
   logic signed [SCORE_W-1:0] lb_in   [WIN-1];
   logic signed [SCORE_W-1:0] lb_out  [WIN-1];

   // Window registers: [row][col], row 0 oldest, col WIN-1 newest.
   logic signed [SCORE_W-1:0] win_q [WIN][WIN];
   logic signed [SCORE_W-1:0] win_d [WIN][WIN];

   logic signed [SCORE_W-1:0] center;
   logic                      beats;
   logic                      interior;
   logic                      hit;

   logic            corner_valid_q, corner_valid_d;
   logic            corner_q, corner_d;
   logic [CX_W-1:0] cx_q, cx_d;
   logic [CY_W-1:0] cy_q, cy_d;
   logic            last_q, last_d;
   logic            frame_done_q, frame_done_d;
   logic [31:0]     frame_cnt_q, frame_cnt_d;
   logic [31:0]     corner_count_q, corner_count_d;
   logic [31:0]     frame_sum;

   // Resolve the current sample's position (sof forces the origin) and advance.
   always_comb begin
      cur_x = sof ? '0 : col_q;
      cur_y = sof ? '0 : row_q;
      col_d = col_q;
      row_d = row_q;
      if (adv) begin
         if (cur_x == X_LAST) begin
            col_d = '0;
            row_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
         end else begin
            col_d = cur_x + 1'b1;
            row_d = cur_y;
         end
      end
   end

   // Chain of line buffers. Buffer k delays by k+1 lines and feeds the next buffer.
   assign col_new[WIN-1] = score;
   for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
      assign lb_in[k]           = col_new[WIN-1-k];
      assign col_new[WIN-2-k]   = lb_out[k];
      harris_line_buffer #(
         .DEPTH (IMG_W),
         .WIDTH (SCORE_W),
         .AW    (CX_W)
      ) u_lb (
         .clk  (clk),
         .we   (adv),
         .addr (cur_x),
         .din  (lb_in[k]),
         .dout (lb_out[k])
      );
   end

   // Shift the window left by one column and append the new column on each sample.
   always_comb begin
      win_d = win_q;
      if (adv) begin
         for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][WIN-1] = col_new[r];
         end
      end
   end

   // Decide on the center of the updated window.
   // Earlier neighbours must be strictly lower; later ones may tie.
   always_comb begin
      center = win_d[R][R];
      beats  = 1'b1;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN; c++) begin
            if (r * WIN + c < CIDX) begin
               if (!(center > win_d[r][c])) beats = 1'b0;
            end else if (r * WIN + c > CIDX) begin
               if (!(center >= win_d[r][c])) beats = 1'b0;
            end
         end
      end
      // Below 2R the window straddles a line or frame wrap. Right and bottom
      // border centers never arise because x,y cannot exceed the last pixel.
      interior = (cur_x >= X_MIN) && (cur_y >= Y_MIN);
      hit      = adv && interior && (center > threshold) && beats;
   end

   // Result registers and per-frame corner accounting.
   always_comb begin
      corner_valid_d = adv;
      corner_d       = hit;
      cx_d           = cx_q;
      cy_d           = cy_q;
      last_d         = 1'b0;
      frame_done_d   = last_q;
      frame_cnt_d    = frame_cnt_q;
      corner_count_d = corner_count_q;
      frame_sum      = '0;
      if (adv) begin
         cx_d      = interior ? cur_x - CX_OFF : '0;
         cy_d      = interior ? cur_y - CY_OFF : '0;
         // sof restarts the tally, which discards any partially counted frame.
         frame_sum = (sof ? 32'd0 : frame_cnt_q) + {31'd0, hit};
         if ((cur_x == X_LAST) && (cur_y == Y_LAST)) begin
            last_d         = 1'b1;
            frame_cnt_d    = '0;
            corner_count_d = frame_sum;
         end else begin
            frame_cnt_d = frame_sum;
         end
      end
   end

   // Control and status state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q          <= '0;
         row_q          <= '0;
         corner_valid_q <= 1'b0;
         corner_q       <= 1'b0;
         cx_q           <= '0;
         cy_q           <= '0;
         last_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_cnt_q    <= '0;
         corner_count_q <= '0;
      end else begin
         col_q          <= col_d;
         row_q          <= row_d;
         corner_valid_q <= corner_valid_d;
         corner_q       <= corner_d;
         cx_q           <= cx_d;
         cy_q           <= cy_d;
         last_q         <= last_d;
         frame_done_q   <= frame_done_d;
         frame_cnt_q    <= frame_cnt_d;
         corner_count_q <= corner_count_d;
      end
   end

   // Window data path. It needs no reset because the interior gate masks stale contents.
   always_ff @(posedge clk) begin
      win_q <= win_d;
   end

   assign corner_valid = corner_valid_q;
   assign corner       = corner_q;
   assign cx           = cx_q;
   assign cy           = cy_q;
   assign frame_done   = frame_done_q;
   assign corner_count = corner_count_q;

endmodule

// File: tb/tb_harris_nms_stream.sv
// Bench for harris_nms_stream on an 8x8 frame with a 3x3 window.
module tb_harris_nms_stream;
   import harris_pkg::*;

   localparam int IMG_W = 8;
   localparam int IMG_H = 8;
   localparam int WIN   = 3;
   localparam int R     = (WIN - 1) / 2;
   localparam int CW    = 3;
   localparam int EW    = 1 + 2 * CW;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset;
   score_t        score;
   logic          score_valid;
   logic          sof;
   score_t        threshold;
   logic          corner_valid;
   logic          corner;
   logic [CW-1:0] cx;
   logic [CW-1:0] cy;
   logic          frame_done;
   logic [31:0]   corner_count;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   harris_nms_stream #(
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H),
      .SCORE_W (32),
      .WIN     (WIN)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .score        (score),
      .score_valid  (score_valid),
      .sof          (sof),
      .threshold    (threshold),
      .corner_valid (corner_valid),
      .corner       (corner),
      .cx           (cx),
      .cy           (cy),
      .frame_done   (frame_done),
      .corner_count (corner_count)
   );

   // ---------------- reference model ----------------
   score_t img   [IMG_H][IMG_W];
   score_t thr_a [IMG_H][IMG_W];

   // Decision for the sample at (x,y): {corner, cy, cx}, taken straight from the frame picture.
   function automatic logic [EW-1:0] model_pulse(input int x, input int y);
      int     cxm, cym;
      score_t c, n;
      logic   h;
      bit     earlier;
      if (x < 2 * R || y < 2 * R) return '0;
      cxm = x - R;
      cym = y - R;
      c   = img[cym][cxm];
      h   = (c > thr_a[y][x]);
      if (cxm < R || cym < R || cxm > IMG_W - 1 - R || cym > IMG_H - 1 - R) h = 1'b0;
      for (int dy = -R; dy <= R; dy++) begin
         for (int dx = -R; dx <= R; dx++) begin
            if (dy == 0 && dx == 0) continue;
            n       = img[cym+dy][cxm+dx];
            earlier = (dy < 0) || (dy == 0 && dx < 0);
            if (earlier ? (c <= n) : (c < n)) h = 1'b0;
         end
      end
      return {h, CW'(cym), CW'(cxm)};
   endfunction

   task automatic fill(input score_t v, input score_t t);
      for (int y = 0; y < IMG_H; y++)
         for (int x = 0; x < IMG_W; x++) begin
            img[y][x]   = v;
            thr_a[y][x] = t;
         end
   endtask

   task automatic fill_random(input bit big);
      for (int y = 0; y < IMG_H; y++)
         for (int x = 0; x < IMG_W; x++) begin
            if (big) begin
               case ($urandom_range(0, 4))
                  0:       img[y][x] = 32'sh8000_0000;
                  1:       img[y][x] = 32'sh7fff_ffff;
                  2:       img[y][x] = 32'sh0000_0001;
                  3:       img[y][x] = -32'sd1;
                  default: img[y][x] = score_t'($urandom);
               endcase
               thr_a[y][x] = score_t'($urandom);
            end else begin
               img[y][x]   = score_t'(int'($urandom_range(0, 8)) - 4);
               thr_a[y][x] = score_t'(int'($urandom_range(0, 6)) - 4);
            end
         end
   endtask

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   int            fd_q[$];
   int            exp_total;
   int            chk_cnt  = 0;
   int            pass_cnt = 0;
   int            fail_cnt = 0;
   bit            mon_en   = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      chk_cnt++;
      assert (obs === exp_v) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Per-cycle check of the pulse stream and of frame_done timing.
   always @(negedge clk) begin : mon
      logic          expv;
      logic          fdv;
      logic [EW-1:0] e;
      int            drop;
      if (mon_en) begin
         while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            drop = exp_cyc_q.pop_front();
            e    = exp_q.pop_front();
         end
         expv = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
         check("corner_valid", 64'(corner_valid), 64'(expv));
         if (expv && corner_valid) begin
            drop = exp_cyc_q.pop_front();
            e    = exp_q.pop_front();
            check("pulse", 64'({corner, cy, cx}), 64'(e));
         end
         while (fd_q.size() > 0 && fd_q[0] < cyc) drop = fd_q.pop_front();
         fdv = (fd_q.size() > 0) && (fd_q[0] == cyc);
         check("frame_done", 64'(frame_done), 64'(fdv));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_cycle();
      @(posedge clk);
      #1;
      score_valid = 1'b0;
      sof         = 1'b0;
      score       = score_t'($urandom);
      threshold   = score_t'($urandom);
   endtask

   task automatic send_frame(input int n, input bit with_sof, input bit gaps);
      int            x, y;
      logic [EW-1:0] e;
      exp_total = 0;
      for (int i = 0; i < n; i++) begin
         x = i % IMG_W;
         y = i / IMG_W;
         if (gaps)
            for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) idle_cycle();
         @(posedge clk);
         #1;
         score_valid = 1'b1;
         sof         = with_sof && (i == 0);
         score       = img[y][x];
         threshold   = thr_a[y][x];
         e = model_pulse(x, y);
         exp_q.push_back(e);
         exp_cyc_q.push_back(cyc + 1);
         exp_total += int'(e[EW-1]);
         if (x == IMG_W - 1 && y == IMG_H - 1) fd_q.push_back(cyc + 2);
      end
      @(posedge clk);
      #1;
      score_valid = 1'b0;
      sof         = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_cv"},  64'(corner_valid), 64'(0));
      check({tag, "_c"},   64'(corner),       64'(0));
      check({tag, "_cx"},  64'(cx),           64'(0));
      check({tag, "_cy"},  64'(cy),           64'(0));
      check({tag, "_fd"},  64'(frame_done),   64'(0));
      check({tag, "_cnt"}, 64'(corner_count), 64'(0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int keep;
      reset       = 1'b1;
      score_valid = 1'b0;
      sof         = 1'b0;
      score       = '0;
      threshold   = '0;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      check_zero_outputs("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Flat zero frame: ties everywhere, no corners.
      fill(0, -1);
      send_frame(64, 1'b1, 1'b0);
      settle();
      check("cnt_flat", 64'(corner_count), 64'(0));

      // Single peak.
      fill(0, 50);
      img[4][4] = 100;
      send_frame(64, 1'b1, 1'b0);
      settle();
      check("cnt_peak", 64'(corner_count), 64'(1));

      // Equal horizontal pair: only the earlier one wins.
      fill(0, 50);
      img[3][3] = 100;
      img[3][4] = 100;
      send_frame(64, 1'b1, 1'b0);
      settle();
      check("cnt_tie", 64'(corner_count), 64'(1));

      // Peaks on the border are never flagged.
      fill(0, 50);
      img[3][0] = 100;
      img[7][7] = 100;
      send_frame(64, 1'b1, 1'b0);
      settle();
      check("cnt_border", 64'(corner_count), 64'(0));

      // Negative scores, signed compare.
      fill(-10, -8);
      img[4][4] = -5;
      send_frame(64, 1'b1, 1'b0);
      settle();
      check("cnt_signed", 64'(corner_count), 64'(1));

      // Full-range values.
      for (int f = 0; f < 2; f++) begin
         fill_random(1'b1);
         send_frame(64, 1'b1, 1'b1);
         settle();
         check("cnt_big", 64'(corner_count), 64'(exp_total));
      end

      // Random small-range frames with frequent ties and gaps.
      for (int f = 0; f < 4; f++) begin
         fill_random(1'b0);
         send_frame(64, 1'b1, 1'b1);
         settle();
         check("cnt_rand", 64'(corner_count), 64'(exp_total));
      end

      // Aborted frame carries a corner in its first 20 samples, then sof restarts.
      keep = exp_total;
      fill(0, -1);
      img[1][2] = 100;
      send_frame(20, 1'b1, 1'b1);
      repeat (3) idle_cycle();
      settle();
      check("cnt_abort_keep", 64'(corner_count), 64'(keep));
      fill_random(1'b0);
      send_frame(64, 1'b1, 1'b1);
      settle();
      check("cnt_after_abort", 64'(corner_count), 64'(exp_total));

      // Frame with one corner, then reset mid-frame.
      fill(0, 50);
      img[4][4] = 100;
      send_frame(64, 1'b1, 1'b0);
      settle();
      check("cnt_pre_reset", 64'(corner_count), 64'(1));
      fill_random(1'b0);
      send_frame(30, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_zero_outputs("midreset");
      // A valid sample coincident with reset must be discarded.
      score_valid = 1'b1;
      score       = 77;
      threshold   = -100;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      score_valid = 1'b0;
      @(negedge clk);
      check_zero_outputs("rstvalid");

      // Without sof, the frame must start from (0,0) after reset.
      fill(-10, -8);
      img[4][4] = -5;
      send_frame(64, 1'b0, 1'b1);
      settle();
      check("cnt_post_reset", 64'(corner_count), 64'(1));

      repeat (4) @(negedge clk);
      check("drain_pulses", 64'(exp_q.size()), 64'(0));
      check("drain_frames", 64'(fd_q.size()), 64'(0));

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
